// File: rtl/operand_fetch_pkg.sv
// Shared decode constants for the operand-fetch stage and EX: opcodes,
// per-opcode attribute table and instruction field positions.
package operand_fetch_pkg;

    localparam int XLEN  = 16;
    localparam int RA_W  = 3;
    localparam int CNT_W = 16;

    localparam logic [3:0] OPC_ADD  = 4'd0;
    localparam logic [3:0] OPC_SUB  = 4'd1;
    localparam logic [3:0] OPC_AND  = 4'd2;
    localparam logic [3:0] OPC_OR   = 4'd3;
    localparam logic [3:0] OPC_XOR  = 4'd4;
    localparam logic [3:0] OPC_ADDI = 4'd5;
    localparam logic [3:0] OPC_ANDI = 4'd6;
    localparam logic [3:0] OPC_LW   = 4'd7;
    localparam logic [3:0] OPC_SW   = 4'd8;
    localparam logic [3:0] OPC_BEQ  = 4'd9;
    localparam logic [3:0] OPC_JMP  = 4'd10;
    localparam logic [3:0] OPC_LUI  = 4'd11;

    // Attribute table: bit N describes opcode N.
    localparam logic [15:0] OPC_USES_RS2  = 16'h031F;
    localparam logic [15:0] OPC_WRITES_RD = 16'h08FF;
    localparam logic [15:0] OPC_IS_LOAD   = 16'h0080;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/operand_fetch_instr_attr_decode.sv
// Opcode to attribute lookup; the same block is instantiated in EX.
module instr_attr_decode
    import operand_fetch_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       uses_rs2,
    output logic       writes_rd,
    output logic       is_load
);

    assign uses_rs2  = OPC_USES_RS2[opcode];
    assign writes_rd = OPC_WRITES_RD[opcode];
    assign is_load   = OPC_IS_LOAD[opcode];

endmodule

// File: rtl/operand_fetch.sv
// ID/operand-fetch stage: decode, EX/WB forwarding, load-use stall and a
// valid/ready ID/EX register.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic [15:0]      in_pc,
    output logic [RA_W-1:0]  rf_rs1_addr,
    output logic [RA_W-1:0]  rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             wb_we,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_pc,
    output logic [3:0]       out_opcode,
    output logic [RA_W-1:0]  out_rd,
    output logic [XLEN-1:0]  out_op_a,
    output logic [XLEN-1:0]  out_op_b,
    output logic             out_wr_en,
    output logic             out_is_load,
    output logic [CNT_W-1:0] stall_count
);

    logic [3:0]       opcode;
    logic [RA_W-1:0]  rd, rs1, rs2;
    logic [XLEN-1:0]  imm;
    logic             uses_rs2, writes_rd, is_load;
    logic             hazard, adv;
    logic [XLEN-1:0]  op_a, op_b;

    logic             out_valid_d, out_valid_q;
    logic [15:0]      out_pc_d, out_pc_q;
    logic [3:0]       out_opcode_d, out_opcode_q;
    logic [RA_W-1:0]  out_rd_d, out_rd_q;
    logic [XLEN-1:0]  out_op_a_d, out_op_a_q;
    logic [XLEN-1:0]  out_op_b_d, out_op_b_q;
    logic             out_wr_en_d, out_wr_en_q;
    logic             out_is_load_d, out_is_load_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // EX beats WB because it is the younger producer; a load in EX is skipped
    // since its data does not exist yet (the hazard logic stalls instead).
    function automatic logic [XLEN-1:0] fwd(
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_we,
        input logic            ex_ld,
        input logic [RA_W-1:0] ex_dst,
        input logic [XLEN-1:0] ex_val,
        input logic            wb_en,
        input logic [RA_W-1:0] wb_dst,
        input logic [XLEN-1:0] wb_val
    );
        if (rs == '0)                               return '0;
        else if (ex_we && !ex_ld && ex_dst == rs)   return ex_val;
        else if (wb_en && wb_dst == rs)             return wb_val;
        else                                        return rf_data;
    endfunction

    assign opcode = in_instr[OPC_MSB:OPC_LSB];
    assign rd     = in_instr[RD_MSB:RD_LSB];
    assign rs1    = in_instr[RS1_MSB:RS1_LSB];
    assign rs2    = in_instr[RS2_MSB:RS2_LSB];
    assign imm    = {{(XLEN-6){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    instr_attr_decode u_attr (
        .opcode    (opcode),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load)
    );

    assign op_a = fwd(rs1, rf_rs1_data, ex_wr_en, ex_is_load, ex_rd, ex_result,
                      wb_we, wb_rd, wb_data);
    assign op_b = uses_rs2 ? fwd(rs2, rf_rs2_data, ex_wr_en, ex_is_load, ex_rd,
                                 ex_result, wb_we, wb_rd, wb_data)
                           : imm;

    assign hazard = in_valid && ex_wr_en && ex_is_load && (ex_rd != '0) &&
                    ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !hazard && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_opcode_d  = out_opcode_q;
        out_rd_d      = out_rd_q;
        out_op_a_d    = out_op_a_q;
        out_op_b_d    = out_op_b_q;
        out_wr_en_d   = out_wr_en_q;
        out_is_load_d = out_is_load_q;
        stall_cnt_d   = stall_cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (adv && in_valid && !hazard) begin
            out_valid_d   = 1'b1;
            out_pc_d      = in_pc;
            out_opcode_d  = opcode;
            out_rd_d      = rd;
            out_op_a_d    = op_a;
            out_op_b_d    = op_b;
            out_wr_en_d   = writes_rd && (rd != '0);
            out_is_load_d = is_load;
        end else if (adv) begin
            out_valid_d = 1'b0;
        end

        if (hazard && adv && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_opcode_q  <= '0;
            out_rd_q      <= '0;
            out_op_a_q    <= '0;
            out_op_b_q    <= '0;
            out_wr_en_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_opcode_q  <= out_opcode_d;
            out_rd_q      <= out_rd_d;
            out_op_a_q    <= out_op_a_d;
            out_op_b_q    <= out_op_b_d;
            out_wr_en_q   <= out_wr_en_d;
            out_is_load_q <= out_is_load_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_opcode  = out_opcode_q;
    assign out_rd      = out_rd_q;
    assign out_op_a    = out_op_a_q;
    assign out_op_b    = out_op_b_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_is_load = out_is_load_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random stimulus for operand_fetch, checked against a
// cycle-level reference model of the stage kept in this bench.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_instr, in_pc;
    logic [2:0]  rf_rs1_addr, rf_rs2_addr;
    logic [15:0] rf_rs1_data, rf_rs2_data;
    logic        ex_wr_en, ex_is_load;
    logic [2:0]  ex_rd;
    logic [15:0] ex_result;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] out_pc;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [15:0] out_op_a, out_op_b;
    logic        out_wr_en, out_is_load;
    logic [15:0] stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] rf [8];

    // reference model state
    logic        m_valid;
    logic [15:0] m_pc;
    logic [3:0]  m_op;
    logic [2:0]  m_rd;
    logic [15:0] m_a, m_b;
    logic        m_wr, m_ld;
    logic [15:0] m_stall;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_wr_en(out_wr_en), .out_is_load(out_is_load),
        .stall_count(stall_count)
    );

    // ISA: 0-4 R-type ALU, 5/6 ALU-imm, 7 load, 8 store, 9 branch, 10 jump,
    // 11 lui, 12-15 no-op.
    function automatic bit isa_uses_rs2(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
    endfunction
    function automatic bit isa_writes_rd(input logic [3:0] op);
        return (op <= 4'd7) || (op == 4'd11);
    endfunction

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1,
                                       input int low6);
        return {op[3:0], rd[2:0], rs1[2:0], low6[5:0]};
    endfunction

    function automatic logic [15:0] resolve(input logic [2:0] rs);
        if (rs == 3'd0) return 16'h0;
        if (ex_wr_en && !ex_is_load && ex_rd == rs) return ex_result;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf[rs];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_op = 0; m_rd = 0; m_a = 0; m_b = 0;
        m_wr = 0; m_ld = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("stall_count", stall_count, m_stall);
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_opcode", out_opcode, m_op);
            chk("out_rd", out_rd, m_rd);
            chk("out_op_a", out_op_a, m_a);
            chk("out_op_b", out_op_b, m_b);
            chk("out_wr_en", out_wr_en, m_wr);
            chk("out_is_load", out_is_load, m_ld);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_pc"}, out_pc, 0);
        chk({tag, "_opcode"}, out_opcode, 0);
        chk({tag, "_rd"}, out_rd, 0);
        chk({tag, "_op_a"}, out_op_a, 0);
        chk({tag, "_op_b"}, out_op_b, 0);
        chk({tag, "_wr_en"}, out_wr_en, 0);
        chk({tag, "_is_load"}, out_is_load, 0);
        chk({tag, "_stall"}, stall_count, 0);
    endtask

    // Called just after a rising edge with inputs already driven; ends #1
    // after the next rising edge with the model advanced and outputs checked.
    task automatic step();
        logic [3:0]  op;
        logic [2:0]  rs1, rs2, rd;
        logic        u2, hz, adv;
        logic        n_valid;
        logic [15:0] n_a, n_b;
        op  = in_instr[15:12];
        rd  = in_instr[11:9];
        rs1 = in_instr[8:6];
        rs2 = in_instr[5:3];
        rf_rs1_data = rf[rs1];
        rf_rs2_data = rf[rs2];
        #1;
        u2  = isa_uses_rs2(op);
        hz  = in_valid && ex_wr_en && ex_is_load && ex_rd != 3'd0 &&
              (ex_rd == rs1 || (u2 && ex_rd == rs2));
        adv = !m_valid || out_ready;
        chk("in_ready", in_ready, adv && !hz && !flush);
        chk("rf_rs1_addr", rf_rs1_addr, rs1);
        chk("rf_rs2_addr", rf_rs2_addr, rs2);
        n_a = resolve(rs1);
        n_b = u2 ? resolve(rs2) : {{10{in_instr[5]}}, in_instr[5:0]};
        n_valid = m_valid;
        @(posedge clk);
        if (hz && adv && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (flush) n_valid = 0;
        else if (adv && in_valid && !hz) begin
            n_valid = 1;
            m_pc = in_pc; m_op = op; m_rd = rd; m_a = n_a; m_b = n_b;
            m_wr = isa_writes_rd(op) && rd != 3'd0;
            m_ld = (op == 4'd7);
        end else if (adv) n_valid = 0;
        m_valid = n_valid;
        #1;
        check_outputs();
    endtask

    task automatic idle_ex_wb();
        ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 1;
        rf_rs1_data = 0; rf_rs2_data = 0;
        idle_ex_wb();
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;

        // basic fetch
        rf[3] = 16'h1234;
        in_valid = 1; in_pc = 16'h0100; in_instr = mk(0, 1, 3, 6'b000_000);
        step();
        chk("basic_valid", out_valid, 1);
        chk("basic_op_a", out_op_a, 16'h1234);
        chk("basic_op_b", out_op_b, 16'h0000);

        // forwarding priority
        rf[2] = 16'h1111;
        in_pc = 16'h0102; in_instr = mk(5, 1, 2, 6'd1);
        ex_wr_en = 1; ex_rd = 2; ex_result = 16'hAAAA;
        wb_we = 1; wb_rd = 2; wb_data = 16'h5555;
        step();
        chk("fwd_ex", out_op_a, 16'hAAAA);
        ex_wr_en = 0;
        step();
        chk("fwd_wb", out_op_a, 16'h5555);
        wb_we = 0;
        step();
        chk("fwd_rf", out_op_a, 16'h1111);

        // load-use on rs2: one bubble, then accepted via WB forward
        in_pc = 16'h0104; in_instr = mk(0, 5, 1, {3'd4, 3'd0});
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 4; ex_result = 16'hDEAD;
        step();
        chk("lu_bubble", out_valid, 0);
        chk("lu_stall", stall_count, 1);
        idle_ex_wb();
        wb_we = 1; wb_rd = 4; wb_data = 16'hBEEF;
        step();
        chk("lu_accept", out_valid, 1);
        chk("lu_op_b", out_op_b, 16'hBEEF);
        wb_we = 0;

        // load in EX matching only the imm field of an I-type, and load to R0
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 4;
        in_pc = 16'h0106; in_instr = mk(5, 3, 1, {3'd4, 3'd3});
        step();
        chk("itype_nostall", out_op_b, 16'hFFE3);
        ex_rd = 0;
        in_pc = 16'h0108; in_instr = mk(0, 3, 0, 6'd0);
        step();
        chk("r0_nostall", stall_count, 1);
        idle_ex_wb();

        // backpressure
        out_ready = 0;
        in_pc = 16'h010A; in_instr = mk(1, 6, 7, {3'd6, 3'd0});
        repeat (3) step();
        chk("bp_pc_held", out_pc, 16'h0108);
        out_ready = 1;
        step();
        chk("bp_release_pc", out_pc, 16'h010A);

        // flush together with in_valid and a load-use hazard
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 7; flush = 1;
        in_pc = 16'h010C; in_instr = mk(2, 1, 7, 6'd0);
        step();
        chk("flush_valid", out_valid, 0);
        flush = 0;
        step();
        // async reset in the middle of a stall cycle
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all_zero("midstall_rst");
        @(posedge clk);
        #1 rst_n = 1;
        idle_ex_wb(); in_valid = 0;

        // random traffic
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_instr   = 16'($urandom);
            in_pc      = 16'($urandom);
            ex_wr_en   = $urandom_range(0, 1) == 1;
            ex_is_load = $urandom_range(0, 2) == 0;
            ex_rd      = 3'($urandom);
            ex_result  = 16'($urandom);
            wb_we      = $urandom_range(0, 1) == 1;
            wb_rd      = 3'($urandom);
            wb_data    = 16'($urandom);
            flush      = $urandom_range(0, 15) == 0;
            out_ready  = $urandom_range(0, 3) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
